uart_tx: RTL and testbench

UART 8N1 serialiser that sits downstream of the UART APB register file. It consumes the register file's tx_en, tx_rst, tx_start and tx_data outputs and returns tx_busy and tx_done to the STATS register. Bytes written to TXDATA are queued in a small FIFO and shifted out LSB-first on txd, with each bit lasting a fixed number of clock cycles.

---
 rtl/uart_tx.sv | 195 +++++++++++++++++++
 tb/tb_uart_tx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART 8N1 transmitter: a small byte FIFO fed by edge-detected write requests.
// The FIFO drains LSB-first onto txd, and each bit lasts CLKS_PER_BIT clocks.
module uart_tx #(
    parameter int CLKS_PER_BIT = 651,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic       tx_rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_full,
    output logic       tx_overflow
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
    localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   PTR_ZERO  = (AW+1)'(0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          done_q, done_d;
    logic          full_q, full_d;
    logic          ovf_q, ovf_d;
    logic          tx_start_q;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic          push_s, pop_s, wr_en_s, empty_s, full_s, baud_end_s;
    logic [7:0]    head_s;

    assign push_s     = tx_start & ~tx_start_q;
    assign empty_s    = (wr_ptr_q == rd_ptr_q);
    assign full_s     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_s     = mem_q[rd_ptr_q[AW-1:0]];
    assign baud_end_s = (baud_q == BAUD_LAST);

    assign txd         = txd_q;
    assign tx_busy     = (state_q != IDLE);
    assign tx_done     = done_q;
    assign tx_full     = full_q;
    assign tx_overflow = ovf_q;

    // Frame sequencer: next state, shift data, line level and pop request
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        done_d  = 1'b0;
        pop_s   = 1'b0;
        if (tx_rst) begin
            state_d = IDLE;
            baud_d  = {BW{1'b0}};
            bit_d   = 3'd0;
            txd_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    txd_d = 1'b1;
                    if (tx_en && !empty_s) begin
                        pop_s   = 1'b1;
                        shift_d = head_s;
                        state_d = START;
                        txd_d   = 1'b0;
                        baud_d  = {BW{1'b0}};
                    end else begin
                        state_d = IDLE;
                    end
                end
                START: begin
                    if (baud_end_s) begin
                        state_d = DATA;
                        bit_d   = 3'd0;
                        txd_d   = shift_q[0];
                        baud_d  = {BW{1'b0}};
                    end else begin
                        baud_d  = baud_q + BAUD_ONE;
                    end
                end
                DATA: begin
                    if (baud_end_s) begin
                        baud_d = {BW{1'b0}};
                        if (bit_q == 3'd7) begin
                            state_d = STOP;
                            txd_d   = 1'b1;
                        end else begin
                            bit_d   = bit_q + 3'd1;
                            txd_d   = shift_q[bit_q + 3'd1];
                        end
                    end else begin
                        baud_d = baud_q + BAUD_ONE;
                    end
                end
                STOP: begin
                    // registered pulse lands on the final stop cycle itself
                    done_d = (baud_q == BAUD_PRE);
                    if (baud_end_s) begin
                        baud_d = {BW{1'b0}};
                        if (tx_en && !empty_s) begin
                            pop_s   = 1'b1;
                            shift_d = head_s;
                            state_d = START;
                            txd_d   = 1'b0;
                        end else begin
                            state_d = IDLE;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        baud_d = baud_q + BAUD_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    txd_d   = 1'b1;
                end
            endcase
        end
    end

    // FIFO pointers, overflow detection and post-edge full flag
    always_comb begin
        wr_en_s  = 1'b0;
        ovf_d    = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (tx_rst) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
        end else begin
            wr_en_s  = push_s && (!full_s || pop_s);
            ovf_d    = push_s && full_s && !pop_s;
            wr_ptr_d = wr_ptr_q + (wr_en_s ? PTR_ONE : PTR_ZERO);
            rd_ptr_d = rd_ptr_q + (pop_s ? PTR_ONE : PTR_ZERO);
        end
        full_d = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                 (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    // State and control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_q     <= {BW{1'b0}};
            bit_q      <= 3'd0;
            shift_q    <= 8'd0;
            txd_q      <= 1'b1;
            done_q     <= 1'b0;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
            tx_start_q <= 1'b0;
            wr_ptr_q   <= PTR_ZERO;
            rd_ptr_q   <= PTR_ZERO;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            done_q     <= done_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
            tx_start_q <= tx_start;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= tx_data;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_tx;
    logic       clk = 1'b0;
    logic       rst;
    logic       tx_en;
    logic       tx_rst;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       txd, tx_busy, tx_done, tx_full, tx_overflow;

    int total = 0;
    int bad   = 0;
    int done_n = 0, ovf_n = 0, busy_n = 0, low_n = 0;

    uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .tx_en(tx_en), .tx_rst(tx_rst),
        .tx_start(tx_start), .tx_data(tx_data), .txd(txd),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_full(tx_full),
        .tx_overflow(tx_overflow)
    );

    always #5 clk = ~clk;

    // free-running event counters; tests compare snapshots
    always @(negedge clk) begin
        if (tx_done)     done_n <= done_n + 1;
        if (tx_overflow) ovf_n  <= ovf_n + 1;
        if (tx_busy)     busy_n <= busy_n + 1;
        if (!txd)        low_n  <= low_n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        tx_data  = b;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
    endtask

    // Wait up to 'bound' cycles for the start bit, then check all ten levels cycle by cycle.
    task automatic expect_frame(input string tag, input logic [7:0] b, input int bound);
        int   n;
        bit   found;
        logic [9:0] lvl;
        logic [3:0] v;
        logic d;
        n = 0;
        found = 1'b0;
        d = 1'b0;
        lvl = {1'b1, b, 1'b0};
        while (!found && n < bound) begin
            step();
            n++;
            if (txd == 1'b0) found = 1'b1;
        end
        chk($sformatf("%s_start", tag), {31'd0, found}, 32'd1);
        if (found) begin
            for (int l = 0; l < 10; l++) begin
                for (int j = 0; j < 4; j++) begin
                    if (!(l == 0 && j == 0)) step();
                    v[j] = txd;
                    if (l == 9 && j == 3) d = tx_done;
                end
                chk($sformatf("%s_lvl%0d", tag, l), {28'd0, v}, {28'd0, {4{lvl[l]}}});
            end
            chk($sformatf("%s_done", tag), {31'd0, d}, 32'd1);
        end
    endtask

    initial begin
        int d0, o0, b0, l0;
        rst = 1'b0; tx_en = 1'b1; tx_rst = 1'b0; tx_start = 1'b0; tx_data = 8'h00;
        #1 rst = 1'b1;
        #1;
        chk("rst_txd",  {31'd0, txd},         32'd1);
        chk("rst_busy", {31'd0, tx_busy},     32'd0);
        chk("rst_done", {31'd0, tx_done},     32'd0);
        chk("rst_full", {31'd0, tx_full},     32'd0);
        chk("rst_ovf",  {31'd0, tx_overflow}, 32'd0);
        repeat (2) step();
        rst = 1'b0;
        repeat (2) step();

        // 1: single frame, exact latency and busy length
        b0 = busy_n; d0 = done_n;
        push(8'hA5);
        chk("t1_idle_after_push", {31'd0, txd}, 32'd1);
        expect_frame("t1", 8'hA5, 1);
        step();
        chk("t1_busy_end", {31'd0, tx_busy}, 32'd0);
        chk("t1_busy_len", busy_n - b0, 32'd40);
        chk("t1_done_cnt", done_n - d0, 32'd1);

        // 2: level-held tx_start yields one frame
        repeat (3) step();
        d0 = done_n; o0 = ovf_n;
        tx_data = 8'h5A; tx_start = 1'b1;
        expect_frame("t2", 8'h5A, 2);
        repeat (59) step();
        tx_start = 1'b0;
        repeat (60) step();
        chk("t2_done_cnt", done_n - d0, 32'd1);
        chk("t2_ovf_cnt",  ovf_n - o0,  32'd0);
        chk("t2_busy",     {31'd0, tx_busy}, 32'd0);

        // 3: fill FIFO, overflow, back-to-back frames
        d0 = done_n; o0 = ovf_n;
        fork
            begin
                for (int i = 1; i <= 6; i++) begin
                    push(8'(i));
                    if (i == 4) chk("t3_not_full", {31'd0, tx_full}, 32'd0);
                    if (i == 5) chk("t3_full", {31'd0, tx_full}, 32'd1);
                    if (i == 6) chk("t3_ovf_pulse", {31'd0, tx_overflow}, 32'd1);
                    step();
                    if (i == 6) chk("t3_ovf_once", {31'd0, tx_overflow}, 32'd0);
                end
            end
            begin
                expect_frame("t3_f1", 8'h01, 2);
                for (int k = 2; k <= 5; k++)
                    expect_frame($sformatf("t3_f%0d", k), 8'(k), 1);
            end
        join
        step();
        chk("t3_idle",     {31'd0, tx_busy}, 32'd0);
        chk("t3_done_cnt", done_n - d0, 32'd5);
        chk("t3_ovf_cnt",  ovf_n - o0,  32'd1);
        chk("t3_empty",    {31'd0, tx_full}, 32'd0);

        // 4: tx_en gating
        repeat (3) step();
        tx_en = 1'b0;
        b0 = busy_n; l0 = low_n;
        push(8'h3C);
        repeat (50) step();
        chk("t4_no_busy", busy_n - b0, 32'd0);
        chk("t4_no_low",  low_n - l0,  32'd0);
        tx_en = 1'b1;
        expect_frame("t4", 8'h3C, 1);

        // 5: soft reset mid-frame with two bytes queued
        repeat (5) step();
        push(8'h11);
        step();
        chk("t5_start", {31'd0, txd}, 32'd0);
        push(8'h22);
        push(8'h33);
        repeat (15) step();
        chk("t5_bit3", {31'd0, txd}, 32'd0);
        chk("t5_busy_pre", {31'd0, tx_busy}, 32'd1);
        d0 = done_n;
        tx_rst = 1'b1;
        step();
        tx_rst = 1'b0;
        chk("t5_txd",  {31'd0, txd},     32'd1);
        chk("t5_busy", {31'd0, tx_busy}, 32'd0);
        chk("t5_full", {31'd0, tx_full}, 32'd0);
        b0 = busy_n;
        repeat (100) step();
        chk("t5_no_done", done_n - d0, 32'd0);
        chk("t5_no_send", busy_n - b0, 32'd0);
        push(8'h81);
        expect_frame("t5", 8'h81, 1);

        // 6: asynchronous reset mid-frame
        repeat (3) step();
        push(8'h96);
        step();
        repeat (10) step();
        chk("t6_busy_pre", {31'd0, tx_busy}, 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("t6_txd",  {31'd0, txd},     32'd1);
        chk("t6_busy", {31'd0, tx_busy}, 32'd0);
        repeat (2) step();
        rst = 1'b0;
        step();
        chk("t6_idle", {31'd0, tx_busy}, 32'd0);
        push(8'hFF);
        expect_frame("t6", 8'hFF, 1);

        repeat (5) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
